// File: rtl/read_iq_pkg.sv
// read_iq_pkg
// Shared definitions for the read_iq byte deinterleaver / quantizer:
//   state_t          - two-phase control state (collect bytes, emit pair)
//   BYTES_PER_SAMPLE - bytes per I/Q group (I_lo, I_hi, Q_lo, Q_hi)
//   quantize()       - sign-extend a 16-bit sample and shift it left into the
//                      downstream fixed-point format
package read_iq_pkg;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam int BYTES_PER_SAMPLE = 4;

  // Result is produced at 64 bits so callers can truncate to their own
  // DATA_WIDTH; with 16 + bits <= width no significant bits are lost.
  function automatic logic [63:0] quantize(input logic [15:0] sample,
                                           input int          bits);
    logic signed [63:0] ext;
    ext = 64'(signed'(sample));
    return ext <<< bits;
  endfunction

endpackage

// File: rtl/read_iq.sv
// read_iq
// Pops raw bytes from a first-word-fall-through byte FIFO, groups them as
// I_lo, I_hi, Q_lo, Q_hi, and writes the quantized I and Q samples as one
// aligned pair into the I and Q FIFOs.
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   in_rd_en          - pop strobe to the input byte FIFO (combinational)
//   in_empty, in_dout - input FIFO status and head byte
//   I_wr_en, I_full, I_din - I FIFO push, full flag, quantized sample
//   Q_wr_en, Q_full, Q_din - Q FIFO push, full flag, quantized sample
// Requires 16 + BITS <= DATA_WIDTH so the shift can never overflow.
module read_iq
  import read_iq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [7:0]            in_dout,
  output logic                  I_wr_en,
  input  logic                  I_full,
  output logic [DATA_WIDTH-1:0] I_din,
  output logic                  Q_wr_en,
  input  logic                  Q_full,
  output logic [DATA_WIDTH-1:0] Q_din
);

  localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_SAMPLE - 1);

  state_t     state_reg, state_next;
  logic [1:0] byte_cnt_reg, byte_cnt_next;

  // Assembled view of the byte slots: [0]=I_lo [1]=I_hi [2]=Q_lo [3]=Q_hi
  logic [BYTES_PER_SAMPLE-1:0][7:0] sample_bytes;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= S_READ;
      byte_cnt_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    in_rd_en      = 1'b0;
    I_wr_en       = 1'b0;
    Q_wr_en       = 1'b0;
    case (state_reg)
      S_READ: begin
        // The reset term keeps the pop strobe quiet while reset is held,
        // since it is otherwise a pure function of in_empty.
        in_rd_en = !in_empty && !reset;
        if (in_rd_en) begin
          byte_cnt_next = byte_cnt_reg + 2'd1;  // wraps to 0 after slot 3
          if (byte_cnt_reg == LAST_SLOT) begin
            state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // Both FIFOs must have room: a lone write would misalign I and Q.
        if (!I_full && !Q_full) begin
          I_wr_en    = 1'b1;
          Q_wr_en    = 1'b1;
          state_next = S_READ;
        end
      end
      default: state_next = S_READ;
    endcase
  end

  // One holding register per byte slot. No pops happen in S_WRITE, so the
  // slots (and therefore I_din/Q_din) are stable for the whole write phase.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_SAMPLE; gi++) begin : g_slot
      logic [7:0] slot_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          slot_reg <= 8'd0;
        end else if (in_rd_en && (byte_cnt_reg == 2'(gi))) begin
          slot_reg <= in_dout;
        end
      end

      assign sample_bytes[gi] = slot_reg;
    end
  endgenerate

  assign I_din = DATA_WIDTH'(quantize({sample_bytes[1], sample_bytes[0]}, BITS));
  assign Q_din = DATA_WIDTH'(quantize({sample_bytes[3], sample_bytes[2]}, BITS));

endmodule

// File: tb/tb_read_iq.sv
// tb_read_iq
// Directed scenarios followed by a randomized stream for read_iq. A byte
// source queue plays the input FIFO; a reference model groups popped bytes
// into I/Q pairs with plain integer arithmetic and predicts pops and writes.
module tb_read_iq;

  localparam int DW   = 32;
  localparam int BITS = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_rd_en;
  logic          in_empty;
  logic [7:0]    in_dout;
  logic          I_wr_en;
  logic          I_full;
  logic [DW-1:0] I_din;
  logic          Q_wr_en;
  logic          Q_full;
  logic [DW-1:0] Q_din;

  read_iq #(.DATA_WIDTH(DW), .BITS(BITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_rd_en (in_rd_en),
    .in_empty (in_empty),
    .in_dout  (in_dout),
    .I_wr_en  (I_wr_en),
    .I_full   (I_full),
    .I_din    (I_din),
    .Q_wr_en  (Q_wr_en),
    .Q_full   (Q_full),
    .Q_din    (Q_din)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Source / model state
  logic [7:0]    src[$];
  logic [7:0]    grp[$];
  logic [DW-1:0] exp_i, exp_q;
  bit            pending;
  int            gap;
  int            hold;
  bit            rand_empty;
  int            writes;
  int            pops;
  logic [DW-1:0] last_i, last_q;

  // Value of a little-endian signed 16-bit sample scaled by 2^BITS.
  function automatic logic [DW-1:0] ref_sample(input logic [7:0] lo,
                                               input logic [7:0] hi);
    int v;
    v = int'($signed({hi, lo}));
    return DW'(v * (1 << BITS));
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, check the
  // combinational strobes, update the model, then advance to the next
  // falling edge.
  task automatic cycle(input bit fi, input bit fq);
    bit exp_rd, exp_wr;
    I_full = fi;
    Q_full = fq;
    if (src.size() == 0 || hold > 0 || (rand_empty && $urandom_range(0, 2) == 0)) begin
      in_empty = 1'b1;
      in_dout  = 8'($urandom);
    end else begin
      in_empty = 1'b0;
      in_dout  = src[0];
    end
    if (hold > 0) hold--;
    #1;
    exp_rd = !in_empty && !pending;
    exp_wr = pending && !fi && !fq;
    check("in_rd_en", DW'(in_rd_en), DW'(exp_rd));
    check("I_wr_en",  DW'(I_wr_en),  DW'(exp_wr));
    check("Q_wr_en",  DW'(Q_wr_en),  DW'(exp_wr));
    if (exp_rd) begin
      grp.push_back(src.pop_front());
      pops++;
      hold = gap;
      if (grp.size() == 4) begin
        exp_i   = ref_sample(grp[0], grp[1]);
        exp_q   = ref_sample(grp[2], grp[3]);
        grp.delete();
        pending = 1'b1;
      end
    end
    if (exp_wr) begin
      check("I_din", I_din, exp_i);
      check("Q_din", Q_din, exp_q);
      $display("pair %0d I=%h Q=%h", writes, I_din, Q_din);
      last_i  = I_din;
      last_q  = Q_din;
      writes++;
      pending = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0);
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    src.push_back(b0);
    src.push_back(b1);
    src.push_back(b2);
    src.push_back(b3);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_empty = 1'b0;
    in_dout  = 8'h5A;
    I_full   = 1'b0;
    Q_full   = 1'b0;
    #1;
    check("rst_rd_en", DW'(in_rd_en), '0);
    check("rst_I_wr",  DW'(I_wr_en),  '0);
    check("rst_Q_wr",  DW'(Q_wr_en),  '0);
    check("rst_I_din", I_din, '0);
    check("rst_Q_din", Q_din, '0);
    grp.delete();
    pending = 1'b0;
    hold    = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int w0;
    int p0;
    int n;
    reset      = 1'b1;
    in_empty   = 1'b1;
    in_dout    = 8'h00;
    I_full     = 1'b0;
    Q_full     = 1'b0;
    pending    = 1'b0;
    gap        = 0;
    hold       = 0;
    rand_empty = 1'b0;
    writes     = 0;
    pops       = 0;
    @(negedge clock);
    do_reset();

    // Single pair
    w0 = writes;
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    run(8);
    check("single_count", DW'(writes - w0), DW'(1));
    check("single_I", last_i, 32'h0048D000);
    check("single_Q", last_q, 32'hFEAF3400);

    // Extremes
    w0 = writes;
    push4(8'h00, 8'h80, 8'hFF, 8'h7F);
    run(8);
    check("extreme_count", DW'(writes - w0), DW'(1));
    check("extreme_I", last_i, 32'hFE000000);
    check("extreme_Q", last_q, 32'h01FFFC00);

    // Starvation: 10 empty cycles after every byte
    w0  = writes;
    gap = 10;
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    push4(8'h00, 8'h80, 8'hFF, 8'h7F);
    run(110);
    gap = 0;
    check("starve_count", DW'(writes - w0), DW'(2));
    check("starve_I", last_i, 32'hFE000000);
    check("starve_Q", last_q, 32'h01FFFC00);

    // Backpressure with a pair pending and more input available
    w0 = writes;
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    push4(8'h01, 8'h00, 8'hFF, 8'hFF);
    run(4);
    p0 = pops;
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0);
    for (int k = 0; k < 3; k++)  cycle(1'b0, 1'b1);
    for (int k = 0; k < 3; k++)  cycle(1'b1, 1'b1);
    check("bp_no_write", DW'(writes - w0), DW'(0));
    check("bp_no_pop", DW'(pops - p0), DW'(0));
    cycle(1'b0, 1'b0);
    check("bp_release", DW'(writes - w0), DW'(1));
    check("bp_I", last_i, 32'h0048D000);
    check("bp_Q", last_q, 32'hFEAF3400);
    run(8);
    check("bp_next_I", last_i, 32'h00000400);
    check("bp_next_Q", last_q, 32'hFFFFFC00);

    // Reset mid-group
    src.push_back(8'h11);
    src.push_back(8'h22);
    run(2);
    check("midrst_popped", DW'(grp.size()), DW'(2));
    do_reset();
    w0 = writes;
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    run(8);
    check("midrst_count", DW'(writes - w0), DW'(1));
    check("midrst_I", last_i, 32'h0048D000);
    check("midrst_Q", last_q, 32'hFEAF3400);

    // Randomized stream: 1000 groups with random empty/full toggling
    w0         = writes;
    rand_empty = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    n = 0;
    while ((src.size() != 0 || pending) && n < 40000) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      n++;
    end
    rand_empty = 1'b0;
    check("stream_drained", DW'(src.size() + int'(pending)), DW'(0));
    check("stream_count", DW'(writes - w0), DW'(1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_iq.md
# read_iq

Front-end deinterleaver and quantizer for the FM radio datapath. It pops raw bytes from the input byte FIFO and assembles each group of four bytes into a little-endian 16-bit signed I sample and Q sample. It scales both samples into the fixed-point format used downstream and writes them as a pair into the I and Q FIFOs, which feed the channel filter and I/Q multiply stages.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the I/Q output samples.
- BITS, 10, fixed-point quantization shift; requires 16 + BITS <= DATA_WIDTH.

Ports:
- clock  input  1  single system clock; all state is in this domain.
- reset  input  1  asynchronous, active-high.
- in_rd_en  output  1  pops one byte from the input FIFO.
- in_empty  input  1  input FIFO empty.
- in_dout  input  8  input FIFO head byte (first-word-fall-through; valid while in_empty=0).
- I_wr_en  output  1  pushes I_din into the I FIFO.
- I_full  input  1  I FIFO full.
- I_din  output  DATA_WIDTH  quantized I sample.
- Q_wr_en  output  1  pushes Q_din into the Q FIFO.
- Q_full  input  1  Q FIFO full.
- Q_din  output  DATA_WIDTH  quantized Q sample.

## Operation
- Byte order on input: I_lo, I_hi, Q_lo, Q_hi. The pattern repeats with no framing marker.
- State S_READ:
  - in_rd_en = !in_empty (combinational). Each popped byte is stored into byte slot byte_cnt (2 bits), then byte_cnt increments.
  - When the byte with byte_cnt==3 is accepted, byte_cnt wraps to 0 and the state moves to S_WRITE.
- State S_WRITE:
  - in_rd_en = 0.
  - When !I_full && !Q_full: I_wr_en = Q_wr_en = 1 for exactly one cycle, then the state returns to S_READ.
  - Otherwise, hold in S_WRITE with both write enables at 0.
- I and Q are always written in the same cycle. A single write is never issued, so the two FIFOs stay sample-aligned.
- Arithmetic:
  - I_din = DATA_WIDTH'(signed'({I_hi, I_lo})) <<< BITS.
  - Q_din is formed the same way from {Q_hi, Q_lo}.
  - Sign-extend before the shift. No rounding and no saturation; the width constraint makes overflow impossible.
- I_din and Q_din are driven from registered sample holding registers and are stable throughout S_WRITE.

## Timing
- Reset values:
  - state = S_READ, byte_cnt = 0, byte registers = 0.
  - in_rd_en = I_wr_en = Q_wr_en = 0 while reset is high. in_rd_en is combinational and follows !in_empty from the first cycle after reset release.
  - I_din = Q_din = 0.
- Best-case throughput: 4 read cycles plus 1 write cycle, so 5 cycles per I/Q pair.
- Latency: I_wr_en/Q_wr_en assert in the cycle immediately after the cycle in which the 4th byte was popped, provided neither output FIFO is full.
- in_empty during S_READ: no pop; byte_cnt and stored bytes hold indefinitely. A partial group resumes exactly where it stopped.
- Backpressure: if exactly one of I_full/Q_full is high, or both are, no write occurs. Writes fire the first cycle both are low.
- No input pops occur while a pair is pending, so the input FIFO absorbs backpressure.
- Reset mid-group or mid-S_WRITE: partial bytes and the pending pair are discarded. After release, the next popped byte is treated as I_lo.

## Structure
- Shared package read_iq_pkg:
  - state enum {S_READ, S_WRITE}.
  - BYTES_PER_SAMPLE = 4 constant.
  - quantize function (sign-extend + shift), also reusable by the golden-model bench.
- No sub-module inside read_iq.
- A thin read_iq_top wrapper instantiates read_iq with the existing fifo module for the 8-bit input FIFO and two DATA_WIDTH output FIFOs. This mirrors the other stage wrappers.

## Test plan
- Single pair: bytes 0x34, 0x12, 0xCD, 0xAB -> one write, I_din = 0x0048D000, Q_din = 0xFEAF3400 (DATA_WIDTH = 32, BITS = 10).
- Extremes: bytes 0x00, 0x80, 0xFF, 0x7F -> I_din = 0xFE000000, Q_din = 0x01FFFC00.
- Input starvation: insert a 10-cycle empty gap after each byte -> in_rd_en low during gaps, outputs identical to the no-gap run, exactly one write per 4 bytes.
- Backpressure: hold I_full = 1, Q_full = 0 for 20 cycles with a pair pending -> no writes and no input pops. Release -> exactly one simultaneous I/Q write.
- Reset mid-group: pop 0x11, 0x22, assert reset, then feed 0x34, 0x12, 0xCD, 0xAB -> the only pair written is I = 0x0048D000, Q = 0xFEAF3400.
- Streaming: 1000 random byte groups with random full/empty toggling -> the I/Q FIFO contents match the C reference read_iq/QUANTIZE output sample-for-sample, with equal counts in both FIFOs.
